shifter_pipe: RTL and testbench



---
 rtl/shifter_pipe_pkg.sv | 18 +
 rtl/shifter_pipe_if.sv | 25 ++
 rtl/shifter_pipe_shift_stage.sv | 29 ++
 rtl/shifter_pipe.sv | 99 +++++++++
 tb/tb_shifter_pipe.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/shifter_pipe_pkg.sv
// Shared WISC datapath definitions used by the shift pipeline:
// mode encodings, flag bit positions and the datapath width.
package shifter_pipe_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    MODE_SLL  = 2'b00,
    MODE_SRA  = 2'b01,
    MODE_ROR  = 2'b10,
    MODE_PASS = 2'b11
  } mode_e;

  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

endpackage

// File: rtl/shifter_pipe_if.sv
// Request/response handshake bundle between the execute stage and the shift unit.
interface shifter_pipe_if;
  import shifter_pipe_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] shift_in;
  logic [3:0]        shift_val;
  logic [1:0]        mode;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] shift_out;
  logic [2:0]        flag;

  modport master (
    output in_valid, shift_in, shift_val, mode, out_ready,
    input  in_ready, out_valid, shift_out, flag
  );

  modport slave (
    input  in_valid, shift_in, shift_val, mode, out_ready,
    output in_ready, out_valid, shift_out, flag
  );

endinterface

// File: rtl/shifter_pipe_shift_stage.sv
// One level of the logarithmic barrel shifter: conditionally shifts by a fixed AMT.
module shift_stage
  import shifter_pipe_pkg::*;
#(
  parameter int AMT = 1
) (
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_en,
  input  logic [1:0]        i_mode,
  input  logic              i_sign,
  output logic [DATA_W-1:0] o_data
);

  logic [DATA_W-1:0] w_shifted;

  // SRA fills from the operand's original sign bit, which travels alongside the data
  always_comb begin
    w_shifted = i_data;
    case (mode_e'(i_mode))
      MODE_SLL: w_shifted = {i_data[DATA_W-AMT-1:0], {AMT{1'b0}}};
      MODE_SRA: w_shifted = {{AMT{i_sign}}, i_data[DATA_W-1:AMT]};
      MODE_ROR: w_shifted = {i_data[AMT-1:0], i_data[DATA_W-1:AMT]};
      default:  w_shifted = i_data;
    endcase
  end

  assign o_data = i_en ? w_shifted : i_data;

endmodule

// File: rtl/shifter_pipe.sv
// Four-stage pipelined barrel shifter (8/4/2/1) with valid/ready on both sides
// and a global stall driven by the output handshake.
module shifter_pipe
  import shifter_pipe_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  shifter_pipe_if.slave bus
);

  logic [STAGES-1:0] r_valid;

  logic [WIDTH-1:0] r_data1, r_data2, r_data3, r_data4;
  logic [2:0]       r_amt1;
  logic [1:0]       r_amt2;
  logic             r_amt3;
  logic [1:0]       r_mode1, r_mode2, r_mode3;
  logic             r_sign1, r_sign2, r_sign3;
  logic [2:0]       r_flag;

  logic [WIDTH-1:0] w_s1, w_s2, w_s3, w_s4;
  logic [2:0]       w_flag;
  logic             w_adv;

  assign w_adv = !r_valid[STAGES-1] || bus.out_ready;

  shift_stage #(.AMT(8)) u_stage1 (
    .i_data(bus.shift_in), .i_en(bus.shift_val[3]), .i_mode(bus.mode),
    .i_sign(bus.shift_in[WIDTH-1]), .o_data(w_s1)
  );

  shift_stage #(.AMT(4)) u_stage2 (
    .i_data(r_data1), .i_en(r_amt1[2]), .i_mode(r_mode1),
    .i_sign(r_sign1), .o_data(w_s2)
  );

  shift_stage #(.AMT(2)) u_stage3 (
    .i_data(r_data2), .i_en(r_amt2[1]), .i_mode(r_mode2),
    .i_sign(r_sign2), .o_data(w_s3)
  );

  shift_stage #(.AMT(1)) u_stage4 (
    .i_data(r_data3), .i_en(r_amt3), .i_mode(r_mode3),
    .i_sign(r_sign3), .o_data(w_s4)
  );

  always_comb begin
    w_flag         = '0;
    w_flag[FLAG_Z] = (w_s4 == '0);
    w_flag[FLAG_V] = 1'b0;
    w_flag[FLAG_N] = w_s4[WIDTH-1];
  end

  // Whole pipe advances together; invalid stages keep their data while stalled
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_data1 <= '0;
      r_data2 <= '0;
      r_data3 <= '0;
      r_data4 <= '0;
      r_amt1  <= '0;
      r_amt2  <= '0;
      r_amt3  <= 1'b0;
      r_mode1 <= '0;
      r_mode2 <= '0;
      r_mode3 <= '0;
      r_sign1 <= 1'b0;
      r_sign2 <= 1'b0;
      r_sign3 <= 1'b0;
      r_flag  <= '0;
    end else if (w_adv) begin
      r_valid <= {r_valid[STAGES-2:0], bus.in_valid};
      r_data1 <= w_s1;
      r_amt1  <= bus.shift_val[2:0];
      r_mode1 <= bus.mode;
      r_sign1 <= bus.shift_in[WIDTH-1];
      r_data2 <= w_s2;
      r_amt2  <= r_amt1[1:0];
      r_mode2 <= r_mode1;
      r_sign2 <= r_sign1;
      r_data3 <= w_s3;
      r_amt3  <= r_amt2[0];
      r_mode3 <= r_mode2;
      r_sign3 <= r_sign2;
      r_data4 <= w_s4;
      r_flag  <= w_flag;
    end
  end

  assign bus.in_ready  = w_adv;
  assign bus.out_valid = r_valid[STAGES-1];
  assign bus.shift_out = r_data4;
  assign bus.flag      = r_flag;

endmodule

// File: tb/tb_shifter_pipe.sv
// Directed bench for shifter_pipe: reset, single shifts, flags, full-rate stream,
// backpressure and reset while requests are in flight.
module tb_shifter_pipe;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  logic [15:0] reqIn   [16];
  logic [3:0]  reqAmt  [16];
  logic [1:0]  reqMode [16];
  logic [15:0] expOut  [16];
  logic [2:0]  expFlag [16];

  shifter_pipe_if bus ();

  shifter_pipe dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic setReq(input int i, input logic [15:0] din, input logic [3:0] amt,
                        input logic [1:0] md, input logic [15:0] dout, input logic [2:0] fl);
    reqIn[i]   = din;
    reqAmt[i]  = amt;
    reqMode[i] = md;
    expOut[i]  = dout;
    expFlag[i] = fl;
  endtask

  // Streams requests 0..n-1 back to back; after the first result, out_ready drops for stallLen cycles
  task automatic applyStimulus(input int n, input int stallLen, input string tag);
    int sent = 0;
    int got = 0;
    int stallLeft = 0;
    int firstOut = 0;
    int lastOut = 0;
    int extra = 0;
    int acceptCyc[16];
    for (int c = 0; c < 80 && got < n; c++) begin
      @(negedge clk);
      bus.out_ready = (stallLeft == 0);
      bus.in_valid  = (sent < n);
      if (sent < n) begin
        bus.shift_in  = reqIn[sent];
        bus.shift_val = reqAmt[sent];
        bus.mode      = reqMode[sent];
      end
      #1;
      if (stallLeft > 0) begin
        checkOutput($sformatf("%s stall in_ready", tag), 32'(bus.in_ready), 32'd0);
        checkOutput($sformatf("%s stall out_valid", tag), 32'(bus.out_valid), 32'd1);
        checkOutput($sformatf("%s stall hold out", tag), 32'(bus.shift_out), 32'(expOut[got]));
        checkOutput($sformatf("%s stall hold flag", tag), 32'(bus.flag), 32'(expFlag[got]));
        stallLeft--;
      end
      if (bus.out_valid && bus.out_ready) begin
        checkOutput($sformatf("%s[%0d] out", tag, got), 32'(bus.shift_out), 32'(expOut[got]));
        checkOutput($sformatf("%s[%0d] flag", tag, got), 32'(bus.flag), 32'(expFlag[got]));
        if (stallLen == 0)
          checkOutput($sformatf("%s[%0d] latency", tag, got), 32'(c - acceptCyc[got]), 32'd4);
        if (got == 0) begin
          firstOut = c;
          stallLeft = stallLen;
        end
        lastOut = c;
        got++;
      end
      if (bus.in_valid && bus.in_ready) begin
        acceptCyc[sent] = c;
        sent++;
      end
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    checkOutput($sformatf("%s result count", tag), 32'(got), 32'(n));
    if (stallLen == 0 && n > 1)
      checkOutput($sformatf("%s consecutive", tag), 32'(lastOut - firstOut), 32'(n - 1));
    for (int k = 0; k < 6; k++) begin
      #1;
      if (bus.out_valid) extra++;
      @(negedge clk);
    end
    checkOutput($sformatf("%s no extra results", tag), 32'(extra), 32'd0);
  endtask

  initial begin
    int seen;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.shift_in  = '0;
    bus.shift_val = '0;
    bus.mode      = '0;
    bus.out_ready = 1'b0;

    $display("[TB] reset then idle");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("reset out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("reset shift_out", 32'(bus.shift_out), 32'h0000);
    checkOutput("reset flag", 32'(bus.flag), 32'd0);
    checkOutput("reset in_ready", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b1;

    $display("[TB] single requests");
    setReq(0, 16'h1234, 4'd5, 2'b00, 16'h4680, 3'b000);
    applyStimulus(1, 0, "sll5");
    setReq(0, 16'h1234, 4'd4, 2'b10, 16'h4123, 3'b000);
    applyStimulus(1, 0, "ror4");
    setReq(0, 16'h1234, 4'd8, 2'b10, 16'h3412, 3'b000);
    applyStimulus(1, 0, "ror8");
    setReq(0, 16'h1234, 4'd0, 2'b10, 16'h1234, 3'b000);
    applyStimulus(1, 0, "ror0");

    $display("[TB] sign and flags");
    setReq(0, 16'h8000, 4'd15, 2'b01, 16'hFFFF, 3'b001);
    applyStimulus(1, 0, "sra15");
    setReq(0, 16'h1234, 4'd13, 2'b01, 16'h0000, 3'b100);
    applyStimulus(1, 0, "sra13");
    setReq(0, 16'h8000, 4'd1, 2'b00, 16'h0000, 3'b100);
    applyStimulus(1, 0, "sll1");
    setReq(0, 16'h0001, 4'd15, 2'b00, 16'h8000, 3'b001);
    applyStimulus(1, 0, "sll15");

    $display("[TB] full-rate ROR stream");
    setReq(0,  16'h1234, 4'd0,  2'b10, 16'h1234, 3'b000);
    setReq(1,  16'h1234, 4'd1,  2'b10, 16'h091A, 3'b000);
    setReq(2,  16'h1234, 4'd2,  2'b10, 16'h048D, 3'b000);
    setReq(3,  16'h1234, 4'd3,  2'b10, 16'h8246, 3'b001);
    setReq(4,  16'h1234, 4'd4,  2'b10, 16'h4123, 3'b000);
    setReq(5,  16'h1234, 4'd5,  2'b10, 16'hA091, 3'b001);
    setReq(6,  16'h1234, 4'd6,  2'b10, 16'hD048, 3'b001);
    setReq(7,  16'h1234, 4'd7,  2'b10, 16'h6824, 3'b000);
    setReq(8,  16'h1234, 4'd8,  2'b10, 16'h3412, 3'b000);
    setReq(9,  16'h1234, 4'd9,  2'b10, 16'h1A09, 3'b000);
    setReq(10, 16'h1234, 4'd10, 2'b10, 16'h8D04, 3'b001);
    setReq(11, 16'h1234, 4'd11, 2'b10, 16'h4682, 3'b000);
    setReq(12, 16'h1234, 4'd12, 2'b10, 16'h2341, 3'b000);
    setReq(13, 16'h1234, 4'd13, 2'b10, 16'h91A0, 3'b001);
    setReq(14, 16'h1234, 4'd14, 2'b10, 16'h48D0, 3'b000);
    setReq(15, 16'h1234, 4'd15, 2'b10, 16'h2468, 3'b000);
    applyStimulus(16, 0, "stream");

    $display("[TB] backpressure");
    setReq(0, 16'h1234, 4'd5,  2'b00, 16'h4680, 3'b000);
    setReq(1, 16'h8000, 4'd15, 2'b01, 16'hFFFF, 3'b001);
    setReq(2, 16'h1234, 4'd8,  2'b10, 16'h3412, 3'b000);
    setReq(3, 16'hABCD, 4'd7,  2'b11, 16'hABCD, 3'b001);
    setReq(4, 16'h00F0, 4'd4,  2'b00, 16'h0F00, 3'b000);
    setReq(5, 16'hF00F, 4'd4,  2'b10, 16'hFF00, 3'b001);
    applyStimulus(6, 5, "bp");

    $display("[TB] reset mid-flight");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.shift_in  = 16'h1111 << k;
      bus.shift_val = 4'(k + 1);
      bus.mode      = 2'b00;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n        = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 0;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (bus.out_valid) seen++;
      @(negedge clk);
    end
    checkOutput("flushed results", 32'(seen), 32'd0);
    setReq(0, 16'h00F0, 4'd4, 2'b00, 16'h0F00, 3'b000);
    applyStimulus(1, 0, "post-reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
